// File: rtl/cofactor_sequencer_if.sv
// ----------------------------------------------------------------------------
// cofactor_sequencer_if
//   Bundles every handshake and datapath signal of cofactor_sequencer.
//   slave  : the sequencer side (accepts matrix words, drives the determinant
//            unit operands, produces cofactors).
//   master : the environment side (matrix source, determinant unit, sink).
//
//   in_valid/in_ready/in_word        matrix word stream, I_0 first
//   det_opnd[287:0]                  nine 32-bit minor operands, operand k at
//                                    [32k+31:32k], row-major
//   det_res[31:0]                    determinant returned by the external unit
//   out_valid/out_ready/out_word     signed cofactor stream
//   out_idx[3:0]                     slot number of out_word
//   busy                             a matrix is being loaded or processed
// ----------------------------------------------------------------------------
interface cofactor_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic [287:0] det_opnd;
  logic [31:0]  det_res;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic [3:0]   out_idx;
  logic         busy;

  modport slave (
    input  in_valid, in_word, det_res, out_ready,
    output in_ready, det_opnd, out_valid, out_word, out_idx, busy
  );

  modport master (
    output in_valid, in_word, det_res, out_ready,
    input  in_ready, det_opnd, out_valid, out_word, out_idx, busy
  );
endinterface

// File: rtl/cofactor_sequencer.sv
// ----------------------------------------------------------------------------
// cofactor_sequencer
//   Computes the 16 signed 3x3-minor cofactors of a 4x4 single-precision
//   matrix by time-sharing one external 3x3 determinant unit.
//   The matrix is loaded serially (word I_j lands in In[15-j]), then one minor
//   per slot is presented on det_opnd, the returned determinant gets the
//   checkerboard sign (bit 31 flip), and the result is streamed out.
//
// Parameters
//   DET_LAT  cycles from det_opnd presentation to det_res valid (0..8);
//            0 means det_res is combinational and sampled in the issue cycle.
//
// Build option
//   ADJ_TRANSPOSE_EN  when defined, slot n carries the cofactor at (c,r), so
//                     the stream is the adjugate in row-major order; when
//                     undefined, slot n carries the cofactor at (r,c).
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   cofactor_sequencer_if.slave (see interface header)
// ----------------------------------------------------------------------------
module cofactor_sequencer #(
  parameter int unsigned DET_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  cofactor_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_PRESENT
  } state_t;

  state_t       state;
  logic [31:0]  mat [16];     // In[k] = element (k/4, k%4)
  logic [3:0]   load_cnt;
  logic [3:0]   slot;
  logic [3:0]   lat_cnt;

  logic [1:0]   sel_r;
  logic [1:0]   sel_c;
  logic [1:0]   mr;
  logic [1:0]   mc;
  logic         odd_pos;
  logic [287:0] minor_opnd;
  logic [31:0]  signed_res;

  // Minor selection: slot row/column, swapped for the adjugate build.
  always_comb begin
`ifdef ADJ_TRANSPOSE_EN
    sel_r = slot[1:0];
    sel_c = slot[3:2];
`else
    sel_r = slot[3:2];
    sel_c = slot[1:0];
`endif
  end

  // r+c is odd exactly when the low bits of r and c differ; this is the same
  // in both builds because the transpose swaps r and c.
  assign odd_pos    = slot[2] ^ slot[0];
  assign signed_res = {bus.det_res[31] ^ odd_pos, bus.det_res[30:0]};

  // Operand k of the 3x3 minor sits at row k/3, column k%3 of the reduced
  // matrix; skipping the deleted row/column maps it back onto the 4x4 array.
  // NOTE: every variable driven here gets a default before the loop so no
  // latch is inferred for paths that do not assign it.
  always_comb begin
    minor_opnd = '0;
    mr         = '0;
    mc         = '0;
    for (int k = 0; k < 9; k++) begin
      mr = 2'(k / 3);
      mc = 2'(k % 3);
      if (mr >= sel_r) mr = mr + 2'd1;
      if (mc >= sel_c) mc = mc + 2'd1;
      minor_opnd[32*k +: 32] = mat[{mr, mc}];
    end
  end

  // Operands are held constant from issue until the cofactor is handshaken.
  assign bus.det_opnd = (state == ST_LOAD) ? '0 : minor_opnd;
  assign bus.in_ready = (state == ST_LOAD) && !rst;

  // NOTE: the matrix store is plain data with no reset; a reset clears
  // load_cnt, so all 16 entries are rewritten before any minor is issued.
  always_ff @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      mat[~load_cnt] <= bus.in_word;   // ~j == 15 - j for a 4-bit index
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_LOAD;
      load_cnt      <= '0;
      slot          <= '0;
      lat_cnt       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_word  <= '0;
      bus.out_idx   <= '0;
      bus.busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (bus.in_valid) begin
            bus.busy <= 1'b1;
            load_cnt <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
              slot  <= '0;
              state <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          if (DET_LAT == 0) begin
            bus.out_word  <= signed_res;
            bus.out_idx   <= slot;
            bus.out_valid <= 1'b1;
            state         <= ST_PRESENT;
          end else begin
            lat_cnt <= 4'(DET_LAT - 1);
            state   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (lat_cnt == '0) begin
            bus.out_word  <= signed_res;
            bus.out_idx   <= slot;
            bus.out_valid <= 1'b1;
            state         <= ST_PRESENT;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end

        ST_PRESENT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (slot == 4'd15) begin
              bus.busy <= 1'b0;
              state    <= ST_LOAD;
            end else begin
              slot  <= slot + 4'd1;
              state <= ST_ISSUE;
            end
          end
        end

        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cofactor_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cofactor_sequencer
//   Drives matrices into cofactor_sequencer, models the external determinant
//   unit with a DET_LAT-cycle delay, and scores every cofactor against a
//   reference computed from the 4x4 matrix with real arithmetic.
// ----------------------------------------------------------------------------
module tb_cofactor_sequencer;

  localparam int DET_LAT = 3;

  typedef logic [31:0] mat_t [16];

  typedef struct {
    logic [3:0]   idx;
    logic [31:0]  word;
    logic [287:0] opnd;
  } exp_t;

  logic clk;
  logic rst;
  cofactor_sequencer_if bus();

  cofactor_sequencer #(.DET_LAT(DET_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [287:0] act,
                       input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] w);
    real v;
    int  e;
    e = int'(w[30:23]);
    if (e == 0) return 0.0;
    v = 1.0 + $itor(w[22:0]) / 8388608.0;
    if (e >= 127) repeat (e - 127) v = v * 2.0;
    else          repeat (127 - e) v = v / 2.0;
    return w[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    real         a;
    int          e;
    logic        s;
    logic [22:0] m;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e), m};
  endfunction

  function automatic real det3(input logic [287:0] op);
    real a [9];
    for (int i = 0; i < 9; i++) a[i] = f2r(op[32*i +: 32]);
    return a[0] * (a[4] * a[8] - a[5] * a[7])
         - a[1] * (a[3] * a[8] - a[5] * a[6])
         + a[2] * (a[3] * a[7] - a[4] * a[6]);
  endfunction

  function automatic logic [31:0] det_word(input logic [287:0] op);
    return r2f(det3(op));
  endfunction

  // Operands of the minor that output slot n must use.
  function automatic logic [287:0] minor_opnd(input mat_t w, input int n);
    logic [287:0] op;
    int r, c, k;
    r = n / 4;
    c = n % 4;
`ifdef ADJ_TRANSPOSE_EN
    begin int t; t = r; r = c; c = t; end
`endif
    op = '0;
    k  = 0;
    for (int row = 0; row < 4; row++) begin
      if (row == r) continue;
      for (int col = 0; col < 4; col++) begin
        if (col == c) continue;
        op[32*k +: 32] = w[15 - (row * 4 + col)];   // In[k] = I_(15-k)
        k++;
      end
    end
    return op;
  endfunction

  function automatic logic [31:0] rand_elem();
    int v;
    v = int'($urandom_range(0, 16)) - 8;
    return r2f($itor(v));
  endfunction

  task automatic push_matrix(input mat_t w);
    exp_t e;
    for (int n = 0; n < 16; n++) begin
      e.idx  = 4'(n);
      e.opnd = minor_opnd(w, n);
      e.word = det_word(e.opnd);
      if (((n / 4) + (n % 4)) % 2 == 1) e.word[31] = ~e.word[31];
      sb.push_back(e);
    end
  endtask

  // --------------------------------------------------- determinant unit model
  generate
    if (DET_LAT == 0) begin : g_comb
      assign bus.det_res = det_word(bus.det_opnd);
    end else begin : g_pipe
      logic [31:0] det_pipe [DET_LAT];
      always @(posedge clk) begin
        det_pipe[0] <= det_word(bus.det_opnd);
        for (int i = 1; i < DET_LAT; i++) det_pipe[i] <= det_pipe[i-1];
      end
      assign bus.det_res = det_pipe[DET_LAT-1];
    end
  endgenerate

  // ---------------------------------------------------------------- monitor
  logic         hold_prev;
  logic [31:0]  hold_word;
  logic [3:0]   hold_idx;
  logic [287:0] hold_opnd;

  initial hold_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_word",  bus.out_word,  hold_word);
        check("hold_idx",   bus.out_idx,   hold_idx);
        check("hold_opnd",  bus.det_opnd,  hold_opnd);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_idx",  bus.out_idx,  e.idx);
          check("out_word", bus.out_word, e.word);
          check("det_opnd", bus.det_opnd, e.opnd);
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_word = bus.out_word;
      hold_idx  = bus.out_idx;
      hold_opnd = bus.det_opnd;
    end
  end

  // ------------------------------------------------------------- stimulus
  // Entered and left just after a rising edge.
  task automatic load_words(input mat_t w, input int count, input int gap_pct);
    int  guard;
    bit  acc;
    for (int j = 0; j < count; j++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_word  = w[j];
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 2000) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
        guard++;
      end
      check("load_accept", acc, 1'b1);
      if (!acc) break;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic rand_ready(input int cycles);
    repeat (cycles) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sb.size() != 0 || bus.busy || !bus.in_ready) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("idle_in_time", g < 3000, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    mat_t        w;
    mat_t        w2;
    exp_t        e;
    logic [15:0] diag_mask;
    logic [15:0] odd_mask;
    int          g;

    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_word",  bus.out_word,  32'h0);
    check("rst_out_idx",   bus.out_idx,   4'h0);
    check("rst_busy",      bus.busy,      1'b0);
    check("rst_det_opnd",  bus.det_opnd,  288'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Identity matrix: expected words are the fixed pattern of the identity
    diag_mask = 16'h8421;
    odd_mask  = 16'h5A5A;
    foreach (w[j]) w[j] = (j % 5 == 0) ? 32'h3F80_0000 : 32'h0;
    for (int n = 0; n < 16; n++) begin
      e.idx  = 4'(n);
      e.opnd = minor_opnd(w, n);
      e.word = diag_mask[n] ? 32'h3F80_0000 : (odd_mask[n] ? 32'h8000_0000 : 32'h0);
      sb.push_back(e);
    end
    bus.out_ready = 1'b1;
    load_words(w, 16, 0);
    wait_idle();

    // I_j = float(j): issue and presentation timing with out_ready high
    foreach (w[j]) w[j] = r2f($itor(j));
    push_matrix(w);
    load_words(w, 16, 0);               // word 15 accepted in the cycle just ended
    @(negedge clk);                     // t+1
    check("t_issue_opnd",  bus.det_opnd, minor_opnd(w, 0));
    check("t_issue_valid", bus.out_valid, 1'b0);
    repeat (DET_LAT) @(negedge clk);    // t+1+DET_LAT
    check("t_sample_valid", bus.out_valid, 1'b0);
    @(negedge clk);                     // t+2+DET_LAT
    check("t_rise_valid", bus.out_valid, 1'b1);
    check("t_rise_idx",   bus.out_idx,   4'd0);
    @(negedge clk);                     // handshake done, minor 1 issued
    check("t_next_issue_valid", bus.out_valid, 1'b0);
    check("t_next_issue_opnd",  bus.det_opnd,  minor_opnd(w, 1));
    repeat (DET_LAT) @(negedge clk);
    check("t_next_wait_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    check("t_next_rise_valid", bus.out_valid, 1'b1);
    check("t_next_rise_idx",   bus.out_idx,   4'd1);
    @(posedge clk); #1;
    wait_idle();

    // Backpressure at slot 7
    foreach (w[j]) w[j] = rand_elem();
    push_matrix(w);
    load_words(w, 16, 0);
    g = 0;
    @(negedge clk);
    while (!(bus.out_valid && bus.out_idx == 4'd6) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("bp_reach_6", g < 500, 1'b1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    g = 0;
    @(negedge clk);
    while (!bus.out_valid && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("bp_reach_7", g < 500, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus.out_valid, 1'b1);
      check("bp_idx",   bus.out_idx,   4'd7);
      check("bp_opnd",  bus.det_opnd,  minor_opnd(w, 7));
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);                     // handshake cycle
    check("bp_hs_idx", bus.out_idx, 4'd7);
    @(negedge clk);                     // cycle after handshake
    check("bp_issue8_valid", bus.out_valid, 1'b0);
    check("bp_issue8_opnd",  bus.det_opnd,  minor_opnd(w, 8));
    @(posedge clk); #1;
    wait_idle();

    // Reset after 7 words, then a clean load
    foreach (w[j]) w[j] = rand_elem();
    load_words(w, 7, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready_after", bus.in_ready, 1'b1);
    check("mid_rst_busy",           bus.busy,     1'b0);
    check("mid_rst_out_valid",      bus.out_valid, 1'b0);
    @(posedge clk); #1;
    foreach (w2[j]) w2[j] = rand_elem();
    push_matrix(w2);
    load_words(w2, 16, 0);
    wait_idle();

    // Random matrices with input gaps and random backpressure; the last one
    // is upper-triangular
    for (int m = 0; m < 4; m++) begin
      foreach (w[j]) begin
        w[j] = rand_elem();
        if (m == 3 && ((15 - j) / 4) > ((15 - j) % 4)) w[j] = 32'h0;
      end
      push_matrix(w);
      fork
        load_words(w, 16, 30);
        rand_ready(300);
      join
      bus.out_ready = 1'b1;
      wait_idle();
    end

    check("end_busy",     bus.busy,     1'b0);
    check("end_in_ready", bus.in_ready, 1'b1);
    check("end_sb_empty", sb.size(),    0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
